// File: rtl/mips_pkg.sv
// mips_pkg: shared decode definitions for the execute stage.
// Holds the operand width, the decode ALU op codes and the state type of the
// multi-cycle multiply/divide sequencer.
package mips_pkg;

    localparam int XLEN = 32;

    // Decode ALU op set. Only MULT/DIV/MFHI/MFLO concern the mult/div unit;
    // MUL_OP (SPECIAL2, writes rd) is handled elsewhere.
    localparam logic [5:0] NOP_OP  = 6'b000000;
    localparam logic [5:0] MUL_OP  = 6'b000001;
    localparam logic [5:0] MULT_OP = 6'b000010;
    localparam logic [5:0] DIV_OP  = 6'b000011;
    localparam logic [5:0] MFHI_OP = 6'b000100;
    localparam logic [5:0] MFLO_OP = 6'b000101;
    localparam logic [5:0] ADD_OP  = 6'b000110;
    localparam logic [5:0] SUB_OP  = 6'b000111;
    localparam logic [5:0] AND_OP  = 6'b001000;
    localparam logic [5:0] OR_OP   = 6'b001001;
    localparam logic [5:0] XOR_OP  = 6'b001010;
    localparam logic [5:0] NOR_OP  = 6'b001011;
    localparam logic [5:0] SLT_OP  = 6'b001100;
    localparam logic [5:0] SLTU_OP = 6'b001101;
    localparam logic [5:0] SLL_OP  = 6'b001110;
    localparam logic [5:0] SRL_OP  = 6'b001111;
    localparam logic [5:0] SRA_OP  = 6'b010000;
    localparam logic [5:0] LUI_OP  = 6'b010001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } muldiv_state_t;

    // True for every op that either starts a mult/div or reads HI/LO.
    function automatic logic is_hilo_op(input logic [5:0] op);
        return (op == MULT_OP) || (op == DIV_OP) || (op == MFHI_OP) || (op == MFLO_OP);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: sign handling shared by multiply and divide.
// Entry side: converts signed operands to unsigned magnitudes and reports signs.
// Exit side: applies the result sign, either to the whole 2W-bit product or
// separately to the remainder (upper half) and quotient (lower half).
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic           is_signed_i,
    input  logic [W-1:0]   opa_i,
    input  logic [W-1:0]   opb_i,
    output logic [W-1:0]   mag_a_o,
    output logic [W-1:0]   mag_b_o,
    output logic           sign_a_o,
    output logic           sign_b_o,
    input  logic           div_mode_i,
    input  logic           neg_lo_i,
    input  logic           neg_hi_i,
    input  logic [2*W-1:0] res_i,
    output logic [2*W-1:0] res_o
);

    // Magnitudes on entry; |most-negative| wraps to itself, which is right as unsigned.
    always_comb begin
        sign_a_o = is_signed_i & opa_i[W-1];
        sign_b_o = is_signed_i & opb_i[W-1];
        mag_a_o  = sign_a_o ? -opa_i : opa_i;
        mag_b_o  = sign_b_o ? -opb_i : opb_i;
    end

    // Result sign on exit: full-width negate for products, per-half for quotient/remainder.
    always_comb begin
        res_o = res_i;
        if (div_mode_i) begin
            res_o[2*W-1:W] = neg_hi_i ? -res_i[2*W-1:W] : res_i[2*W-1:W];
            res_o[W-1:0]   = neg_lo_i ? -res_i[W-1:0]   : res_i[W-1:0];
        end else begin
            res_o = neg_lo_i ? -res_i : res_i;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO.
// 32-iteration shift-add multiply and restoring divide, one FIXUP cycle that
// applies signs and writes HI/LO. Stalls decode for HI/LO consumers and new
// mult/div ops while busy.
// Build option MULDIV_EARLY_TERM_EN: multiply stops as soon as the remaining
// multiplier bits are all zero; divide latency is unaffected.
//
// Handshake: decode holds issue_valid/aluop/operands stable while stall is
// high; an op is taken at the first rising edge where stall is low.
// CNT_W must satisfy 2**CNT_W > XLEN.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            issue_valid,
    input  logic [5:0]      aluop,
    input  logic            is_signed,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hilo_rdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [1:0]      dbg_state
);

    import mips_pkg::*;

    muldiv_state_t     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;      // product (MUL) or {remainder, quotient} (DIV)
    logic [2*XLEN-1:0] mcand_q;    // multiplicand, shifts left each MUL iteration
    logic [XLEN-1:0]   mplier_q;   // multiplier (shifts right) or divisor (static)
    logic [XLEN-1:0]   raw_a_q;    // unmodified opa for the divide-by-zero result
    logic              sign_a_q;
    logic              sign_b_q;
    logic              is_div_q;
    logic              dz_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              busy_q;
    logic              done_q;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              sign_a;
    logic              sign_b;
    logic [2*XLEN-1:0] res_fixed;

    logic [2*XLEN-1:0] mul_acc_nxt;
    logic [XLEN-1:0]   mplier_shr;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] div_acc_nxt;
    logic              last_iter;
    logic              mul_last;
    logic              start_op;

    muldiv_sign_fix #(.W(XLEN)) u_sign_fix (
        .is_signed_i (is_signed),
        .opa_i       (opa),
        .opb_i       (opb),
        .mag_a_o     (mag_a),
        .mag_b_o     (mag_b),
        .sign_a_o    (sign_a),
        .sign_b_o    (sign_b),
        .div_mode_i  (is_div_q),
        .neg_lo_i    (sign_a_q ^ sign_b_q),
        .neg_hi_i    (sign_a_q),
        .res_i       (acc_q),
        .res_o       (res_fixed)
    );

    // One iteration of multiply and of restoring divide, plus loop-exit decode.
    always_comb begin
        mul_acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shr  = mplier_q >> 1;
        // Remainder < divisor before the shift, so the shifted value fits XLEN+1 bits.
        rem_shift   = acc_q[2*XLEN-1:XLEN-1];
        rem_diff    = rem_shift - {1'b0, mplier_q};
        div_acc_nxt = {acc_q[2*XLEN-2:0], 1'b0};
        if (!rem_diff[XLEN]) begin
            div_acc_nxt = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        last_iter = (cnt_q == CNT_W'(XLEN - 1));
`ifdef MULDIV_EARLY_TERM_EN
        mul_last  = last_iter | (mplier_shr == '0);
`else
        mul_last  = last_iter;
`endif
        start_op  = issue_valid & ~busy_q & ((aluop == MULT_OP) | (aluop == DIV_OP));
    end

    // Sequencer FSM with registered busy/done and HI/LO update in FIXUP.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            raw_a_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_op) begin
                        cnt_q    <= '0;
                        raw_a_q  <= opa;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        mplier_q <= mag_b;
                        busy_q   <= 1'b1;
                        if (aluop == MULT_OP) begin
                            is_div_q <= 1'b0;
                            dz_q     <= 1'b0;
                            acc_q    <= '0;
                            mcand_q  <= {{XLEN{1'b0}}, mag_a};
                            state_q  <= MUL;
                        end else begin
                            is_div_q <= 1'b1;
                            dz_q     <= (opb == '0);
                            acc_q    <= {{XLEN{1'b0}}, mag_a};
                            mcand_q  <= '0;
                            if (opb == '0) begin
                                state_q <= FIXUP;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= DIV;
                            end
                        end
                    end
                end
                MUL: begin
                    acc_q    <= mul_acc_nxt;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_shr;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (mul_last) begin
                        state_q <= FIXUP;
                        done_q  <= 1'b1;
                    end
                end
                DIV: begin
                    acc_q <= div_acc_nxt;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q <= FIXUP;
                        done_q  <= 1'b1;
                    end
                end
                FIXUP: begin
                    if (dz_q) begin
                        hi_q <= raw_a_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= res_fixed[2*XLEN-1:XLEN];
                        lo_q <= res_fixed[XLEN-1:0];
                    end
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall and HI/LO read port are combinational for decode.
    always_comb begin
        stall      = busy_q & issue_valid & is_hilo_op(aluop);
        hilo_rdata = (aluop == MFHI_OP) ? hi_q : lo_q;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule
